// File: rtl/rng_share_if.sv
// rng_share_if: seed/reseed, request/grant and status signals of the random-nibble sharer
interface rng_share_if #(
  parameter int NREQ = 4
);
  logic [3:0]      seed;
  logic            reseed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [3:0]      rnd_data;
  logic            busy;
  logic            seed_fixed;
  logic [7:0]      grant_count;
  modport master (
    output seed, reseed, req,
    input  gnt, rnd_valid, rnd_data, busy, seed_fixed, grant_count
  );
  modport slave (
    input  seed, reseed, req,
    output gnt, rnd_valid, rnd_data, busy, seed_fixed, grant_count
  );
endinterface

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: NLFSR owner sharing random nibbles round-robin; RNG_SHARE_STATS_EN enables grant_count
module rng_share_ctrl #(
  parameter int NREQ            = 4,
  parameter int WARMUP_CYCLES   = 3,
  parameter int STEPS_PER_GRANT = 1
) (
  input logic        clk,
  input logic        reset,
  rng_share_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {LOAD, WARMUP, SERVE, STIR} state_t;
  state_t          state, state_nx;
  logic [3:0]      lfsr, lfsr_step, cnt;
  logic [PW-1:0]   rr_ptr, win, idx;
  logic            hit, grant, seed_fixed;
  logic [NREQ-1:0] gnt;
  assign lfsr_step = {lfsr[2:0], lfsr[3] ^ (lfsr[2] & lfsr[1])};
  // search for the first request after the last winner, wrapping modulo NREQ
  always_comb begin
    hit = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!hit && bus.req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end
  assign grant = state == SERVE && !bus.reseed && hit;
  assign gnt   = grant ? NREQ'(1) << win : '0;
  // sequencing: reseed overrides everything, multi-step phases end when the counter reaches its last step
  always_comb
    state_nx = bus.reseed ? LOAD :
               state == LOAD  ? (WARMUP_CYCLES == 0 ? SERVE : WARMUP) :
               state == SERVE ? (grant && STEPS_PER_GRANT > 1 ? STIR : SERVE) :
               cnt == 4'd1    ? SERVE : state;
  // state, NLFSR, step counter and arbitration pointer; a reseed cycle consumes nothing
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= LOAD;
      lfsr       <= 4'b0001;
      cnt        <= 4'd0;
      rr_ptr     <= PW'(NREQ - 1);
      seed_fixed <= 1'b0;
    end else begin
      state <= state_nx;
      if (!bus.reseed)
        case (state)
          LOAD: begin
            lfsr       <= bus.seed == 4'd0 ? 4'b0001 : bus.seed;
            seed_fixed <= bus.seed == 4'd0;
            cnt        <= 4'(WARMUP_CYCLES);
          end
          WARMUP, STIR: begin
            lfsr <= lfsr_step;
            cnt  <= cnt - 4'd1;
          end
          SERVE: if (grant) begin
            lfsr   <= lfsr_step;
            rr_ptr <= win;
            cnt    <= 4'(STEPS_PER_GRANT - 1);
          end
        endcase
    end
`ifdef RNG_SHARE_STATS_EN
  logic [7:0] grant_count;
  // saturating grant statistics, cleared while loading a seed
  always_ff @(posedge clk or posedge reset)
    if (reset) grant_count <= 8'h00;
    else if (state == LOAD) grant_count <= 8'h00;
    else if (grant && grant_count != 8'hff) grant_count <= grant_count + 8'h01;
  assign bus.grant_count = grant_count;
`else
  assign bus.grant_count = 8'h00;
`endif
  assign bus.gnt        = gnt;
  assign bus.rnd_valid  = grant;
  assign bus.rnd_data   = grant ? lfsr : 4'h0;
  assign bus.busy       = state != SERVE;
  assign bus.seed_fixed = seed_fixed;
endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb_rng_share_ctrl: random stimulus on two controller configurations against a behavioural model
module tb_rng_share_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rng_share_if #(.NREQ(4)) b0 ();
  rng_share_if #(.NREQ(3)) b1 ();
  rng_share_ctrl u0 (.clk(clk), .reset(reset), .bus(b0));
  rng_share_ctrl #(.NREQ(3), .WARMUP_CYCLES(2), .STEPS_PER_GRANT(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
  int total = 0, bad = 0;
  int m_load[2], m_wait[2], m_last[2], m_cnt[2], m_fix[2];
  logic [3:0] m_lfsr[2];
  logic [3:0] clr0;
  logic [2:0] clr1;
  logic [3:0] q0[$];
  int cyc_idx, first_g;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] nstep(input logic [3:0] s);
    return {s[2:0], s[3] ^ (s[2] & s[1])};
  endfunction
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_load[k] = 1; m_wait[k] = 0; m_last[k] = k ? 2 : 3;
      m_cnt[k] = 0; m_fix[k] = 0; m_lfsr[k] = 4'd1;
    end
    clr0 = '0;
    clr1 = '0;
  endtask
  task automatic check_model(input bit upd);
    for (int k = 0; k < 2; k++) begin
      int n = k ? 3 : 4;
      int w = -1;
      int j;
      bit bz = m_load[k] != 0 || m_wait[k] > 0;
      logic [7:0] r = k ? 8'(b1.req) : 8'(b0.req);
      if (!bz && !b0.reseed)
        for (int i = 1; i <= n; i++) begin
          j = (m_last[k] + i) % n;
          if (w < 0 && r[j]) w = j;
        end
      chk($sformatf("gnt%0d", k), k ? int'(b1.gnt) : int'(b0.gnt), w < 0 ? 0 : 1 << w);
      chk($sformatf("valid%0d", k), k ? int'(b1.rnd_valid) : int'(b0.rnd_valid), int'(w >= 0));
      chk($sformatf("data%0d", k), k ? int'(b1.rnd_data) : int'(b0.rnd_data), w >= 0 ? int'(m_lfsr[k]) : 0);
      chk($sformatf("busy%0d", k), k ? int'(b1.busy) : int'(b0.busy), int'(bz));
      chk($sformatf("fixed%0d", k), k ? int'(b1.seed_fixed) : int'(b0.seed_fixed), m_fix[k]);
`ifdef RNG_SHARE_STATS_EN
      chk($sformatf("count%0d", k), k ? int'(b1.grant_count) : int'(b0.grant_count), m_cnt[k]);
`else
      chk($sformatf("count%0d", k), k ? int'(b1.grant_count) : int'(b0.grant_count), 0);
`endif
      if (k == 0 && w >= 0) begin
        q0.push_back(b0.rnd_data);
        if (first_g < 0) first_g = cyc_idx;
      end
      if (upd) begin
        if (m_load[k] != 0) m_cnt[k] = 0;
        if (b0.reseed) m_load[k] = 1;
        else if (m_load[k] != 0) begin
          m_lfsr[k] = b0.seed == 4'd0 ? 4'd1 : b0.seed;
          m_fix[k] = int'(b0.seed == 4'd0);
          m_wait[k] = k ? 2 : 3;
          m_load[k] = 0;
        end else if (m_wait[k] > 0) begin
          m_lfsr[k] = nstep(m_lfsr[k]);
          m_wait[k]--;
        end else if (w >= 0) begin
          m_lfsr[k] = nstep(m_lfsr[k]);
          m_last[k] = w;
          m_wait[k] = k ? 2 : 0;
          if (m_cnt[k] < 255) m_cnt[k]++;
          if (k) clr1[w] = 1'b1;
          else clr0[w] = 1'b1;
        end
      end
    end
  endtask
  task automatic cyc(input logic rs, input logic [3:0] nr0, input logic [2:0] nr1);
    b0.req = (b0.req & ~clr0) | nr0;
    b1.req = (b1.req & ~clr1) | nr1;
    clr0 = '0;
    clr1 = '0;
    b0.reseed = rs;
    b1.reseed = rs;
    #1 check_model(1'b1);
    cyc_idx++;
    @(negedge clk);
  endtask
  task automatic set_seed(input logic [3:0] s);
    b0.seed = s;
    b1.seed = s;
  endtask
  initial begin
    set_seed(4'h6);
    b0.reseed = 1'b0; b1.reseed = 1'b0;
    b0.req = '0; b1.req = '0;
    mreset();
    first_g = -1;
    #1 check_model(1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc_idx = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'b0001, 3'b001);
    chk("first_grant_cycle", first_g, 4);
    chk("seq_len", int'(q0.size() >= 4), 1);
    if (q0.size() >= 4) begin
      chk("seq0", q0[0], 4'h7);
      chk("seq1", q0[1], 4'hf);
      chk("seq2", q0[2], 4'he);
      chk("seq3", q0[3], 4'hc);
    end
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1 mreset();
        check_model(1'b0);
        @(negedge clk);
        reset = 1'b0;
      end
      set_seed($urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom));
      if ($urandom_range(0, 9) == 0) b0.req = b0.req & 4'($urandom);
      if ($urandom_range(0, 9) == 0) b1.req = b1.req & 3'($urandom);
      cyc($urandom_range(0, 39) == 0, 4'($urandom) & 4'($urandom), 3'($urandom) & 3'($urandom));
    end
    set_seed(4'h9);
    for (int c = 0; c < 310; c++) cyc(1'b0, 4'hf, 3'h7);
`ifdef RNG_SHARE_STATS_EN
    chk("count_sat", b0.grant_count, 255);
`else
    chk("count_tied", b0.grant_count, 0);
`endif
    cyc(1'b1, 4'hf, 3'h7);
    cyc(1'b0, 4'hf, 3'h7);
    chk("count_after_reseed", b0.grant_count, 0);
    for (int c = 0; c < 20; c++) cyc(1'b0, 4'hf, 3'h7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
